// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
// The optional HAZARD_PERF_CNT_EN macro, when defined, adds stall/flush performance counters to hazard_ctrl.
package hazard_pkg;

    localparam int REG_IDX_W_DEF = 5;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LU_STALL = 2'd1,
        MC_BUSY  = 2'd2
    } hazard_state_t;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic idex_en;
        logic exmem_en;
        logic memwb_en;
        logic ifid_flush;
        logic idex_flush;
        logic exmem_flush;
        logic memwb_flush;
    } stage_ctrl_t;

    // Free-running pipeline: everything advances, nothing is squashed.
    function automatic stage_ctrl_t ctrl_default();
        stage_ctrl_t c;
        c = '{pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1, exmem_en: 1'b1, memwb_en: 1'b1,
              ifid_flush: 1'b0, idex_flush: 1'b0, exmem_flush: 1'b0, memwb_flush: 1'b0};
        return c;
    endfunction

    // Held in reset: nothing advances, every register is bubbled.
    function automatic stage_ctrl_t ctrl_reset();
        stage_ctrl_t c;
        c = '{pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b0, exmem_en: 1'b0, memwb_en: 1'b0,
              ifid_flush: 1'b1, idex_flush: 1'b1, exmem_flush: 1'b1, memwb_flush: 1'b1};
        return c;
    endfunction

    // Data memory stall: whole pipe frozen, WB receives a bubble.
    function automatic stage_ctrl_t ctrl_mem_wait();
        stage_ctrl_t c;
        c = '{pc_en: 1'b0, ifid_en: 1'b0, idex_en: 1'b0, exmem_en: 1'b0, memwb_en: 1'b1,
              ifid_flush: 1'b0, idex_flush: 1'b0, exmem_flush: 1'b0, memwb_flush: 1'b1};
        return c;
    endfunction

    // Taken branch/jump: squash the two wrong-path instructions behind EX.
    function automatic stage_ctrl_t ctrl_redirect();
        stage_ctrl_t c;
        c = ctrl_default();
        c.ifid_flush = 1'b1;
        c.idex_flush = 1'b1;
        return c;
    endfunction

    // Multi-cycle op in EX: freeze front end, bubble into MEM.
    function automatic stage_ctrl_t ctrl_mc_stall();
        stage_ctrl_t c;
        c = ctrl_default();
        c.pc_en       = 1'b0;
        c.ifid_en     = 1'b0;
        c.idex_en     = 1'b0;
        c.exmem_flush = 1'b1;
        return c;
    endfunction

    // Load-use: hold PC and IF/ID, bubble into EX.
    function automatic stage_ctrl_t ctrl_lu_stall();
        stage_ctrl_t c;
        c = ctrl_default();
        c.pc_en      = 1'b0;
        c.ifid_en    = 1'b0;
        c.idex_flush = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/hazard_ctrl_lu_detect.sv
// Combinational load-use comparator across all ID source ports.
module lu_detect #(
    parameter int NUM_SRC   = 2,
    parameter int REG_IDX_W = hazard_pkg::REG_IDX_W_DEF
) (
    input  logic [NUM_SRC*REG_IDX_W-1:0] id_src_idx,
    input  logic [NUM_SRC-1:0]           id_src_used,
    input  logic [REG_IDX_W-1:0]         ex_rd_idx,
    input  logic                         ex_mem_read,
    output logic                         lu
);
    import hazard_pkg::*;

    logic any_match_s;

    // OR together per-port matches; x0 and unused ports never count.
    always_comb begin
        any_match_s = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (id_src_used[k] && (id_src_idx[k*REG_IDX_W +: REG_IDX_W] == ex_rd_idx)) begin
                any_match_s = 1'b1;
            end else begin
                any_match_s = any_match_s;
            end
        end
    end

    assign lu = ex_mem_read && (ex_rd_idx != '0) && any_match_s;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use, multi-cycle EX, memory wait and redirect handling.
// Optional build macro HAZARD_PERF_CNT_EN adds saturating performance counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int NUM_SRC   = 2,
    parameter int REG_IDX_W = REG_IDX_W_DEF,
    parameter int LOAD_LAT  = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_SRC*REG_IDX_W-1:0] id_src_idx,
    input  logic [NUM_SRC-1:0]           id_src_used,
    input  logic [REG_IDX_W-1:0]         ex_rd_idx,
    input  logic                         ex_mem_read,
    input  logic                         ex_mc_start,
    input  logic                         ex_mc_done,
    input  logic                         ex_redirect,
    input  logic                         mem_wait,
    output logic                         pc_en,
    output logic                         ifid_en,
    output logic                         idex_en,
    output logic                         exmem_en,
    output logic                         memwb_en,
    output logic                         ifid_flush,
    output logic                         idex_flush,
    output logic                         exmem_flush,
    output logic                         memwb_flush
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]                  perf_lu_cycles,
    output logic [31:0]                  perf_mc_cycles,
    output logic [31:0]                  perf_flush_events
`endif
);

    hazard_state_t state_q, state_d;
    logic [2:0]    lu_cnt_q, lu_cnt_d;
    logic          lu_s;
    logic          redirect_acc_s;
    logic          mc_stall_s;
    logic          lu_stall_s;
    stage_ctrl_t   ctrl_s;

    lu_detect #(
        .NUM_SRC   (NUM_SRC),
        .REG_IDX_W (REG_IDX_W)
    ) u_lu_detect (
        .id_src_idx  (id_src_idx),
        .id_src_used (id_src_used),
        .ex_rd_idx   (ex_rd_idx),
        .ex_mem_read (ex_mem_read),
        .lu          (lu_s)
    );

    // Event classification in priority order; mem_wait masks everything below it.
    assign redirect_acc_s = !mem_wait && ex_redirect && (state_q != MC_BUSY);
    assign mc_stall_s     = !mem_wait && !redirect_acc_s && !ex_mc_done &&
                            ((state_q == MC_BUSY) || ((state_q == IDLE) && ex_mc_start));
    assign lu_stall_s     = !mem_wait && !redirect_acc_s && !mc_stall_s &&
                            ((state_q == LU_STALL) || ((state_q == IDLE) && lu_s));

    // State and stall-counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            lu_cnt_q <= 3'd0;
        end else begin
            state_q  <= state_d;
            lu_cnt_q <= lu_cnt_d;
        end
    end

    // Next-state and counter update; mem_wait holds everything.
    always_comb begin
        state_d  = state_q;
        lu_cnt_d = lu_cnt_q;
        if (mem_wait) begin
            state_d  = state_q;
            lu_cnt_d = lu_cnt_q;
        end else if (redirect_acc_s) begin
            state_d  = IDLE;
            lu_cnt_d = 3'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mc_stall_s) begin
                        state_d = MC_BUSY;
                    end else if (lu_stall_s && (LOAD_LAT > 1)) begin
                        state_d  = LU_STALL;
                        lu_cnt_d = 3'(LOAD_LAT - 1);
                    end else begin
                        state_d = IDLE;
                    end
                end
                LU_STALL: begin
                    if (lu_cnt_q == 3'd1) begin
                        state_d  = IDLE;
                        lu_cnt_d = 3'd0;
                    end else begin
                        lu_cnt_d = lu_cnt_q - 3'd1;
                    end
                end
                MC_BUSY: begin
                    if (ex_mc_done) begin
                        state_d = IDLE;
                    end else begin
                        state_d = MC_BUSY;
                    end
                end
                default: begin
                    state_d  = IDLE;
                    lu_cnt_d = 3'd0;
                end
            endcase
        end
    end

    // Zero-latency stage controls; reset forces every register to bubble and hold.
    always_comb begin
        ctrl_s = ctrl_default();
        if (!rst_n) begin
            ctrl_s = ctrl_reset();
        end else if (mem_wait) begin
            ctrl_s = ctrl_mem_wait();
        end else if (redirect_acc_s) begin
            ctrl_s = ctrl_redirect();
        end else if (mc_stall_s) begin
            ctrl_s = ctrl_mc_stall();
        end else if (lu_stall_s) begin
            ctrl_s = ctrl_lu_stall();
        end else begin
            ctrl_s = ctrl_default();
        end
    end

    assign pc_en       = ctrl_s.pc_en;
    assign ifid_en     = ctrl_s.ifid_en;
    assign idex_en     = ctrl_s.idex_en;
    assign exmem_en    = ctrl_s.exmem_en;
    assign memwb_en    = ctrl_s.memwb_en;
    assign ifid_flush  = ctrl_s.ifid_flush;
    assign idex_flush  = ctrl_s.idex_flush;
    assign exmem_flush = ctrl_s.exmem_flush;
    assign memwb_flush = ctrl_s.memwb_flush;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_lu_q, perf_mc_q, perf_flush_q;

    // Saturating counters for attributed stall cycles and accepted redirects.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_lu_q    <= 32'd0;
            perf_mc_q    <= 32'd0;
            perf_flush_q <= 32'd0;
        end else begin
            if (lu_stall_s && (perf_lu_q != 32'hFFFF_FFFF)) begin
                perf_lu_q <= perf_lu_q + 32'd1;
            end
            if (mc_stall_s && (perf_mc_q != 32'hFFFF_FFFF)) begin
                perf_mc_q <= perf_mc_q + 32'd1;
            end
            if (redirect_acc_s && (perf_flush_q != 32'hFFFF_FFFF)) begin
                perf_flush_q <= perf_flush_q + 32'd1;
            end
        end
    end

    assign perf_lu_cycles    = perf_lu_q;
    assign perf_mc_cycles    = perf_mc_q;
    assign perf_flush_events = perf_flush_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: two instances (LOAD_LAT=1 and LOAD_LAT=3) share stimulus.
module tb_hazard_ctrl;

    // {pc,ifid,idex,exmem,memwb, ifid_f,idex_f,exmem_f,memwb_f}
    localparam logic [8:0] C_DEF   = 9'b11111_0000;
    localparam logic [8:0] C_RESET = 9'b00000_1111;
    localparam logic [8:0] C_MEMW  = 9'b00001_0001;
    localparam logic [8:0] C_REDIR = 9'b11111_1100;
    localparam logic [8:0] C_MC    = 9'b00011_0010;
    localparam logic [8:0] C_LU    = 9'b00111_0100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  id_src_idx;
    logic [1:0]  id_src_used;
    logic [4:0]  ex_rd_idx;
    logic        ex_mem_read, ex_mc_start, ex_mc_done, ex_redirect, mem_wait;

    logic [8:0]  act [2];
    logic [8:0]  q_exp [2][$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model state: remaining load-use bubbles after this cycle, and MC occupancy.
    int  lat     [2] = '{1, 3};
    int  lu_left [2] = '{0, 0};
    bit  mc_on   [2] = '{1'b0, 1'b0};

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic pe, fe, de, me, we, ff, df, mf, wf;
`ifdef HAZARD_PERF_CNT_EN
        logic [31:0] p_lu, p_mc, p_fl;
`endif
        hazard_ctrl #(.NUM_SRC(2), .REG_IDX_W(5), .LOAD_LAT(g == 0 ? 1 : 3)) u_dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .id_src_idx  (id_src_idx),
            .id_src_used (id_src_used),
            .ex_rd_idx   (ex_rd_idx),
            .ex_mem_read (ex_mem_read),
            .ex_mc_start (ex_mc_start),
            .ex_mc_done  (ex_mc_done),
            .ex_redirect (ex_redirect),
            .mem_wait    (mem_wait),
            .pc_en       (pe),
            .ifid_en     (fe),
            .idex_en     (de),
            .exmem_en    (me),
            .memwb_en    (we),
            .ifid_flush  (ff),
            .idex_flush  (df),
            .exmem_flush (mf),
            .memwb_flush (wf)
`ifdef HAZARD_PERF_CNT_EN
            ,
            .perf_lu_cycles    (p_lu),
            .perf_mc_cycles    (p_mc),
            .perf_flush_events (p_fl)
`endif
        );
        assign act[g] = {pe, fe, de, me, we, ff, df, mf, wf};
    end

    // Is any used source port reading the register the EX load writes?
    function automatic bit load_use();
        bit hit = 1'b0;
        if (ex_mem_read && ex_rd_idx != 5'd0) begin
            for (int k = 0; k < 2; k++) begin
                if (id_src_used[k] && id_src_idx[k*5 +: 5] == ex_rd_idx) hit = 1'b1;
            end
        end
        return hit;
    endfunction

    // Expected controls for this cycle from the priority rules; advances the model by one edge.
    function automatic logic [8:0] model_step(int i);
        if (mem_wait) return C_MEMW;
        if (ex_redirect && !mc_on[i]) begin
            lu_left[i] = 0;
            return C_REDIR;
        end
        if (mc_on[i]) begin
            if (ex_mc_done) begin
                mc_on[i] = 1'b0;
                return C_DEF;
            end
            return C_MC;
        end
        if (lu_left[i] > 0) begin
            lu_left[i]--;
            return C_LU;
        end
        if (ex_mc_start && !ex_mc_done) begin
            mc_on[i] = 1'b1;
            return C_MC;
        end
        if (load_use()) begin
            lu_left[i] = lat[i] - 1;
            return C_LU;
        end
        return C_DEF;
    endfunction

    // Drive one cycle of inputs, record expectations, advance to just after the next edge.
    task automatic step(input logic [9:0] idx, input logic [1:0] used, input logic [4:0] rd,
                        input logic mr, input logic mcs, input logic mcd,
                        input logic redir, input logic mw);
        id_src_idx  = idx;
        id_src_used = used;
        ex_rd_idx   = rd;
        ex_mem_read = mr;
        ex_mc_start = mcs;
        ex_mc_done  = mcd;
        ex_redirect = redir;
        mem_wait    = mw;
        for (int i = 0; i < 2; i++) q_exp[i].push_back(model_step(i));
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) step(10'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_reset(input string tag);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (act[i] !== C_RESET) begin
                errors++;
                $display("FAIL %s dut%0d actual=%b required=%b", tag, i, act[i], C_RESET);
            end
        end
    endtask

    // Monitor: compare DUT controls against the oldest expectation, mid-cycle.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (q_exp[i].size() > 0) begin
                logic [8:0] e;
                e = q_exp[i].pop_front();
                checks++;
                if (act[i] !== e) begin
                    errors++;
                    $display("FAIL ctrl dut%0d cycle %0d actual=%b required=%b", i, cyc, act[i], e);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        id_src_idx = 10'd0; id_src_used = 2'b00; ex_rd_idx = 5'd0;
        ex_mem_read = 1'b0; ex_mc_start = 1'b0; ex_mc_done = 1'b0;
        ex_redirect = 1'b0; mem_wait = 1'b0;
        #2;
        check_reset("reset_outputs");
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);

        // Load rd=5 consumed by src0: 1 bubble (LAT1) / 3 bubbles (LAT3).
        step({5'd0, 5'd5}, 2'b01, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(4);
        // Same load with mem_wait on the second stall cycle.
        step({5'd0, 5'd5}, 2'b01, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step(10'd0, 2'b00, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(4);
        // x0 load and unused matching port never stall.
        step({5'd0, 5'd0}, 2'b11, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step({5'd7, 5'd1}, 2'b01, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step({5'd9, 5'd3}, 2'b10, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1);
        // Multi-cycle op: four busy cycles then done; then start+done together.
        for (int j = 0; j < 4; j++) step(10'd0, 2'b00, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(10'd0, 2'b00, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(10'd0, 2'b00, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(1);
        // Redirect beats a concurrent load-use.
        step({5'd0, 5'd5}, 2'b01, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        idle(2);
        // Redirect ignored while MC is busy.
        step(10'd0, 2'b00, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(10'd0, 2'b00, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        step(10'd0, 2'b00, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(1);
        // Reset asserted mid-MC_BUSY.
        step(10'd0, 2'b00, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(10'd0, 2'b00, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        check_reset("reset_mid_mc");
        for (int i = 0; i < 2; i++) begin
            lu_left[i] = 0;
            mc_on[i]   = 1'b0;
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);

        // Randomized traffic with small register indices to provoke matches.
        for (int j = 0; j < 600; j++) begin
            logic [9:0] ri;
            logic [4:0] rd;
            ri = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
            rd = 5'($urandom_range(0, 3));
            step(ri, 2'($urandom_range(0, 3)), rd,
                 1'($urandom_range(0, 99) < 40),
                 1'($urandom_range(0, 99) < 20),
                 1'($urandom_range(0, 99) < 30),
                 1'($urandom_range(0, 99) < 10),
                 1'($urandom_range(0, 99) < 12));
        end

        @(negedge clk); #1;
        checks++;
        if (q_exp[0].size() != 0 || q_exp[1].size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d/%0d required=0/0", q_exp[0].size(), q_exp[1].size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Parametrised pipeline hazard controller for the 5-stage RISC-V core. Generalises load-use detection to N source ports and a configurable load-to-use latency.
- Adds multi-cycle EX-op stalls (mul/div handshake), data-memory wait freeze and branch/jump redirect flush.
- Drives all pipeline-register enables and flushes from one FSM plus a stall counter.

Parameters:
- NUM_SRC, 2, number of ID-stage source register ports checked.
- REG_IDX_W, 5, register index width.
- LOAD_LAT, 1, bubble cycles required between a load in EX and a dependent consumer (1..7).

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- id_src_idx  in  NUM_SRC*REG_IDX_W  ID source indices, port k at bits [k*REG_IDX_W +: REG_IDX_W]
- id_src_used  in  NUM_SRC  port k actually read by ID instruction
- ex_rd_idx  in  REG_IDX_W  EX destination register
- ex_mem_read  in  1  EX instruction is a load
- ex_mc_start  in  1  EX holds a multi-cycle op (valid every cycle it sits in EX)
- ex_mc_done  in  1  multi-cycle result ready this cycle
- ex_redirect  in  1  EX resolved taken branch/jump
- mem_wait  in  1  data memory not ready, MEM must hold
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  stage register enables
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  insert bubble into that register

Behaviour:
- States: IDLE, LU_STALL, MC_BUSY. Stall counter lu_cnt is 3 bits.
- Reset: state=IDLE, lu_cnt=0.
- While rst_n=0, all *_en=0 and all *_flush=1.
- Outputs are combinational from state and inputs, with zero latency.
- Default (no event): all en=1, all flush=0.
- Load-use hazard (lu): ex_mem_read && ex_rd_idx!=0 && any k with id_src_used[k] && id_src_idx[k]==ex_rd_idx.
- Priority, highest first: mem_wait > ex_redirect > MC > LU.
- mem_wait=1:
  - All en=0 except memwb_en=1; memwb_flush=1. All other flushes 0.
  - State and lu_cnt hold. The event is not consumed.
- ex_redirect=1 (no mem_wait, state!=MC_BUSY):
  - ifid_flush=1, idex_flush=1, all en=1.
  - Next state IDLE, lu_cnt cleared. A concurrent lu is discarded.
  - ex_redirect is ignored in MC_BUSY.
- MC:
  - In IDLE with ex_mc_start=1 and ex_mc_done=0: pc_en=ifid_en=idex_en=0, exmem_flush=1. Next state MC_BUSY.
  - In MC_BUSY: same outputs until ex_mc_done=1. That cycle all en=1, no flush; next state IDLE.
  - ex_mc_start && ex_mc_done in the same IDLE cycle: no stall.
- LU:
  - In IDLE with lu=1: pc_en=ifid_en=0, idex_flush=1.
  - If LOAD_LAT>1: next state LU_STALL, lu_cnt=LOAD_LAT-1.
  - In LU_STALL: same outputs; lu_cnt decrements each non-mem_wait cycle. When lu_cnt==1, next state IDLE.
  - LOAD_LAT=1 gives exactly one bubble and stays IDLE.
- x0 is never a hazard.
- An unused source port (id_src_used=0) never triggers a hazard.
- Reset mid-stall returns to IDLE immediately, asynchronously.

Optional Feature:
- HAZARD_PERF_CNT_EN defined:
  - Adds outputs perf_lu_cycles, perf_mc_cycles, perf_flush_events (32 bits each, reset 0, saturating).
  - perf_lu_cycles and perf_mc_cycles increment per stall cycle attributed to LU or MC. perf_flush_events increments per accepted redirect.
- Undefined: the ports and counters do not exist.

Decomposition:
- Shared package hazard_pkg:
  - hazard_state_t enum {IDLE, LU_STALL, MC_BUSY}.
  - stage_ctrl_t struct bundling the enable/flush bits.
  - REG_IDX_W default constant.
- Sub-module lu_detect: combinational NUM_SRC-way comparator producing lu.
- FSM and counter stay in hazard_ctrl.

Test Plan:
- Load rd=5 in EX, ID src0=5 used, LOAD_LAT=1 -> one cycle of pc_en=0, ifid_en=0, idex_flush=1, then default outputs.
- LOAD_LAT=3, same load -> three consecutive stall cycles. Inject mem_wait on cycle 2 -> freeze for that cycle, then two further stall cycles.
- Load rd=0, or src port 1 matches but id_src_used[1]=0 -> no stall.
- ex_mc_start held, ex_mc_done after 4 cycles -> 4 cycles of front freeze plus exmem_flush; the done cycle has all en=1. Start and done together -> no stall.
- ex_redirect concurrent with lu -> ifid_flush=idex_flush=1, pc_en=1, no LU_STALL entry.
- rst_n pulled low during MC_BUSY -> all en=0 and flush=1 immediately; after release, IDLE with default outputs.
